// File: rtl/ava_indexed_mode_pkg.sv
// ---------------------------------------------------------------------------
// ava_indexed_mode_pkg
//   Shared types and constants for the AVA palette-indexed pixel fetcher.
//   - bpp_e          : runtime pixel depth selector (1/2/4/8 bits per pixel)
//   - VRAM_WORD_BITS : width of one VRAM word (pixels are packed LSB-first)
//   - bpp_bits()     : bits per pixel for a bpp_e
//   - ppw_log2()     : log2 of pixels per VRAM word for a bpp_e
//   - idx_mask()     : 8-bit mask covering one pixel index at a given depth
// ---------------------------------------------------------------------------
package ava_indexed_mode_pkg;

  localparam int LINEAR_COORDS_BITS = 20;
  localparam int VRAM_ADDR_WIDTH    = 16;
  localparam int PRAM_ADDR_WIDTH    = 10;
  localparam int VRAM_WORD_BITS     = 32;

  typedef enum logic [1:0] {
    BPP1 = 2'd0,
    BPP2 = 2'd1,
    BPP4 = 2'd2,
    BPP8 = 2'd3
  } bpp_e;

  // Bits per pixel: 1, 2, 4 or 8.
  function automatic logic [3:0] bpp_bits(input bpp_e bpp);
    return 4'd1 << bpp;
  endfunction

  // Pixels per 32-bit word is 32 >> bpp, so its log2 is 5 - bpp.
  function automatic logic [2:0] ppw_log2(input bpp_e bpp);
    return 3'd5 - {1'b0, bpp};
  endfunction

  // Mask selecting the low bpp_bits() bits of a palette index.
  function automatic logic [7:0] idx_mask(input bpp_e bpp);
    logic [7:0] mask;
    unique case (bpp)
      BPP1:    mask = 8'h01;
      BPP2:    mask = 8'h03;
      BPP4:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/ava_indexed_mode_if.sv
// ---------------------------------------------------------------------------
// ava_indexed_mode_if
//   Bundles the pixel request, VRAM port, palette RAM port and pixel output of
//   the indexed-mode fetcher.
//   modport master : the fetcher (drives vram_a/vram_re/palette_a/pixel_*)
//   modport slave  : the surrounding pipeline and memories
//   Signals:
//     next_pixel, frame_start, bpp_sel, linear_coords : pixel request side
//     vram_a, vram_re, vram_d                         : VRAM, 1-cycle sync read
//     palette_a, palette_d                            : palette RAM, 1-cycle read
//     pixel_out, pixel_valid                          : resulting color
//     palette_bank (only with AVA_PALETTE_BANK_EN)    : sub-palette select
// ---------------------------------------------------------------------------
interface ava_indexed_mode_if #(
  parameter int LINEAR_COORDS_BITS = ava_indexed_mode_pkg::LINEAR_COORDS_BITS,
  parameter int VRAM_ADDR_WIDTH    = ava_indexed_mode_pkg::VRAM_ADDR_WIDTH,
  parameter int PRAM_ADDR_WIDTH    = ava_indexed_mode_pkg::PRAM_ADDR_WIDTH,
  parameter int COLOR_BITS         = 24
) ();
  import ava_indexed_mode_pkg::*;

  logic                          next_pixel;
  logic                          frame_start;
  bpp_e                          bpp_sel;
  logic [LINEAR_COORDS_BITS-1:0] linear_coords;
  logic [VRAM_ADDR_WIDTH-1:0]    vram_a;
  logic                          vram_re;
  logic [VRAM_WORD_BITS-1:0]     vram_d;
  logic [PRAM_ADDR_WIDTH-1:0]    palette_a;
  logic [31:0]                   palette_d;
  logic [COLOR_BITS-1:0]         pixel_out;
  logic                          pixel_valid;
`ifdef AVA_PALETTE_BANK_EN
  logic [7:0]                    palette_bank;
`endif

  modport master (
    input  next_pixel, frame_start, bpp_sel, linear_coords, vram_d, palette_d,
`ifdef AVA_PALETTE_BANK_EN
    input  palette_bank,
`endif
    output vram_a, vram_re, palette_a, pixel_out, pixel_valid
  );

  modport slave (
    output next_pixel, frame_start, bpp_sel, linear_coords, vram_d, palette_d,
`ifdef AVA_PALETTE_BANK_EN
    output palette_bank,
`endif
    input  vram_a, vram_re, palette_a, pixel_out, pixel_valid
  );

endinterface

// File: rtl/ava_indexed_mode_pixel_extract.sv
// ---------------------------------------------------------------------------
// ava_pixel_extract
//   Combinational pixel field extractor, shared by the packed-pixel modes.
//   Pulls pixel number `off` out of a 32-bit VRAM word whose pixels are packed
//   LSB-first at `bpp` bits each, and returns it zero-extended to 8 bits.
//   Ports:
//     word (in, 32) : VRAM word holding the pixel
//     off  (in, 5)  : pixel position within the word (< pixels per word)
//     bpp  (in, 2)  : pixel depth
//     idx  (out, 8) : palette index
// ---------------------------------------------------------------------------
module ava_pixel_extract
  import ava_indexed_mode_pkg::*;
(
  input  logic [VRAM_WORD_BITS-1:0] word,
  input  logic [4:0]                off,
  input  bpp_e                      bpp,
  output logic [7:0]                idx
);

  logic [4:0]                shamt;
  logic [VRAM_WORD_BITS-1:0] shifted;

  // NOTE: every variable of an always_comb gets a value on every path (here
  // unconditionally), otherwise synthesis infers a latch.
  always_comb begin
    // off < 32/bpp, so off*bpp never exceeds 31 and fits the 5-bit shift.
    shamt   = 5'(9'(off) * 9'(bpp_bits(bpp)));
    shifted = word >> shamt;
    idx     = shifted[7:0] & idx_mask(bpp);
  end

endmodule

// File: rtl/ava_indexed_mode.sv
// ---------------------------------------------------------------------------
// ava_indexed_mode
//   Palette-indexed pixel fetcher for the AVA video pipeline. Pixels are 1, 2,
//   4 or 8 bits wide (selected at frame start), packed LSB-first in 32-bit
//   VRAM words. A one-word cache means VRAM is only read when the pixel stream
//   moves to a different word; the extracted index is looked up in palette RAM
//   to give a 24-bit color two cycles after the request.
//
//   Pipeline:  request cycle : word address/miss computed, VRAM read issued
//              S1            : word selected (cache or VRAM), index extracted,
//                              palette read issued
//              S2            : palette data presented as pixel_out
//
//   Ports:
//     clk     (in)  pixel-domain clock
//     reset_n (in)  asynchronous active-low reset
//     bus     (ava_indexed_mode_if.master) request, VRAM, palette and output
//
//   Build option: define AVA_PALETTE_BANK_EN to add bus.palette_bank; its bits
//   above the pixel depth select a sub-palette (8bpp is unaffected).
// ---------------------------------------------------------------------------
module ava_indexed_mode #(
  parameter int LINEAR_COORDS_BITS = ava_indexed_mode_pkg::LINEAR_COORDS_BITS,
  parameter int VRAM_ADDR_WIDTH    = ava_indexed_mode_pkg::VRAM_ADDR_WIDTH,
  parameter int PRAM_ADDR_WIDTH    = ava_indexed_mode_pkg::PRAM_ADDR_WIDTH,
  parameter int COLOR_BITS         = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ava_indexed_mode_if.master     bus
);
  import ava_indexed_mode_pkg::*;

  // Configuration and cache state
  bpp_e                       bpp_q;
  logic                       cache_valid;
  logic [VRAM_ADDR_WIDTH-1:0] tag;
  logic [VRAM_WORD_BITS-1:0]  word_buf;

  // Request-cycle decode
  bpp_e                       eff_bpp;
  logic [2:0]                 ppw_sh;
  logic [VRAM_ADDR_WIDTH-1:0] word_idx;
  logic [4:0]                 off;
  logic                       miss;

  // S1 pipeline registers
  logic                       s1_valid;
  logic                       s1_hit;
  logic [4:0]                 s1_off;
  bpp_e                       s1_bpp;

  // S1 datapath
  logic [VRAM_WORD_BITS-1:0]  src_word;
  logic [7:0]                 pix_idx;
  logic [7:0]                 bank_bits;
  logic [7:0]                 pal_addr8;

  // S2
  logic                       pixel_valid_q;

  // -------------------------------------------------------------------------
  // Request decode. A frame_start arriving with a request takes effect first:
  // the fetch uses the newly selected depth and is always treated as a miss.
  // -------------------------------------------------------------------------
  always_comb begin
    eff_bpp  = bus.frame_start ? bus.bpp_sel : bpp_q;
    ppw_sh   = ppw_log2(eff_bpp);
    // Word index wraps silently at the VRAM address width.
    word_idx = VRAM_ADDR_WIDTH'(bus.linear_coords >> ppw_sh);
    off      = 5'(bus.linear_coords) & 5'((6'd1 << ppw_sh) - 6'd1);
    miss     = bus.frame_start | ~cache_valid | (tag != word_idx);
  end

  assign bus.vram_a  = word_idx;
  // Gated by reset_n so no read is requested while the block is held in reset.
  assign bus.vram_re = bus.next_pixel & miss & reset_n;

  // -------------------------------------------------------------------------
  // Depth latch and cache tag. When frame_start and a missing fetch coincide,
  // the later cache_valid assignment wins, so the freshly fetched word is
  // cached under the new depth.
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking (<=) assignments so every flop
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bpp_q       <= BPP8;
      cache_valid <= 1'b0;
      tag         <= '0;
    end else begin
      if (bus.frame_start) begin
        bpp_q       <= bus.bpp_sel;
        cache_valid <= 1'b0;
      end
      if (bus.next_pixel && miss) begin
        tag         <= word_idx;
        cache_valid <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // S1 registers. The depth travels with the pixel so a frame_start landing
  // while a pixel is in flight does not change how that pixel is decoded.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_off   <= '0;
      s1_bpp   <= BPP8;
    end else begin
      s1_valid <= bus.next_pixel;
      if (bus.next_pixel) begin
        s1_hit <= ~miss;
        s1_off <= off;
        s1_bpp <= eff_bpp;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Word buffer: captures the VRAM data at the end of a missing S1 so that a
  // back-to-back request to the same word (which hit in its request cycle)
  // finds it in its own S1.
  // -------------------------------------------------------------------------
  // NOTE: word_buf is a single register, not a RAM array, so it is safe and
  // cheap to give it an asynchronous reset value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_buf <= '0;
    end else if (s1_valid && !s1_hit) begin
      word_buf <= bus.vram_d;
    end
  end

  assign src_word = s1_hit ? word_buf : bus.vram_d;

  ava_pixel_extract u_extract (
    .word (src_word),
    .off  (s1_off),
    .bpp  (s1_bpp),
    .idx  (pix_idx)
  );

`ifdef AVA_PALETTE_BANK_EN
  // Bank bits only fill the index positions the pixel itself does not use.
  assign bank_bits = bus.palette_bank & ~idx_mask(s1_bpp);
`else
  assign bank_bits = 8'h00;
`endif

  assign pal_addr8     = pix_idx | bank_bits;
  // Palette address bits above [7:0] are always zero.
  assign bus.palette_a = PRAM_ADDR_WIDTH'(pal_addr8);

  // -------------------------------------------------------------------------
  // S2: the palette read issued in S1 returns now.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_valid_q <= 1'b0;
    end else begin
      pixel_valid_q <= s1_valid;
    end
  end

  assign bus.pixel_valid = pixel_valid_q;
  assign bus.pixel_out   = bus.palette_d[COLOR_BITS-1:0];

  // Palette entries carry color in the low bits only; the top byte is spare.
  logic unused_palette_hi;
  assign unused_palette_hi = ^bus.palette_d[31:COLOR_BITS];

endmodule
